// File: rtl/ps2_defs.sv
// ps2_defs
// Shared definitions for the PS/2 receive path: receiver state encoding,
// frame geometry, start/stop line levels and a constant-foldable clog2
// used to size counters and FIFO pointers.
package ps2_defs;

  // Receiver states: waiting for a start bit, collecting bits, judging the frame
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DPS   = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Number of bits needed to hold the values 0 .. value-1 (0 for value <= 1)
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_buf.sv
// ps2_rx_fifo_buf
// Synchronous first-word-fall-through byte FIFO holding received scan codes.
// The head entry is visible on dout_o whenever empty_o is low; a pop simply
// advances to the next entry. Pointers are clog2(DEPTH) bits and wrap on
// their own, so DEPTH must be a power of two.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset, flushes the FIFO
//   push_i   write din_i (accepted when not full, or full while popping)
//   din_i    byte to write
//   pop_i    remove head entry (ignored when empty)
//   dout_o   head entry, 0 when empty
//   empty_o  no entries stored
//   full_o   DEPTH entries stored
//   count_o  current occupancy
module ps2_rx_fifo_buf
  import ps2_defs::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [7:0]            din_i,
  input  logic                  pop_i,
  output logic [7:0]            dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int PW = clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW:0]   count_q, count_d;
  logic          doPush;
  logic          doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = empty_o ? 8'h00 : mem_q[rdPtr_q];

  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can land there safely.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  // Next pointer and occupancy values
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (doPop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    if (doPush) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (doPush && !doPop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (doPop && !doPush) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  // Pointer and occupancy registers; reset flushes the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible while empty
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= din_i;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// PS/2 device-to-host receiver with a glitch filter on the PS/2 clock, a
// two-flop synchroniser on the PS/2 data line, full frame validation
// (start, odd parity, stop), an inter-bit watchdog and a receive FIFO.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   ps2c, ps2d    raw PS/2 clock and data pins
//   rx_en         permits a new frame to start
//   rd            pop the FIFO head
//   dout          FIFO head (first-word fall-through), valid when empty=0
//   empty, full   FIFO status
//   count         FIFO occupancy
//   busy          a frame is being received or checked
//   rx_done_tick  one-cycle pulse: a valid byte was pushed
//   parity_err, frame_err, timeout_err, overflow
//                 one-cycle error pulses, at most one per frame
module ps2_rx_fifo
  import ps2_defs::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ps2c,
  input  logic                       ps2d,
  input  logic                       rx_en,
  input  logic                       rd,
  output logic [7:0]                 dout,
  output logic                       empty,
  output logic                       full,
  output logic [clog2(FIFO_DEPTH):0] count,
  output logic                       busy,
  output logic                       rx_done_tick,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       timeout_err,
  output logic                       overflow
);

  localparam int BW = clog2(FRAME_BITS);
  localparam int WW = clog2(TIMEOUT_CYC);

  logic [FILTER_LEN-1:0] filterReg_q, filterReg_d;
  logic                  filtClk_q, filtClk_d;
  logic                  dMeta_q;
  logic                  dSync_q;
  logic                  fallEdge;

  rx_state_e             state_q, state_d;
  logic [BW-1:0]         bitCnt_q, bitCnt_d;
  logic [WW-1:0]         wdog_q, wdog_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;

  logic                  startBit;
  logic                  stopBit;
  logic                  parityBit;
  logic [7:0]            dataByte;
  logic                  fifoPush;
  logic                  fifoPop;

  // The filtered clock only moves once FILTER_LEN consecutive samples agree,
  // so any excursion shorter than that leaves it untouched.
  always_comb begin
    filterReg_d = {filterReg_q[FILTER_LEN-2:0], ps2c};
    filtClk_d   = filtClk_q;
    if (&filterReg_q) begin
      filtClk_d = 1'b1;
    end else if (~|filterReg_q) begin
      filtClk_d = 1'b0;
    end
  end

  assign fallEdge = filtClk_q & ~filtClk_d;

  // Clock filter and data synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filterReg_q <= '1;
      filtClk_q   <= 1'b1;
      dMeta_q     <= 1'b1;
      dSync_q     <= 1'b1;
    end else begin
      filterReg_q <= filterReg_d;
      filtClk_q   <= filtClk_d;
      dMeta_q     <= ps2d;
      dSync_q     <= dMeta_q;
    end
  end

  // Bits enter at the MSB and shift right, so after the full frame the
  // start bit sits at bit 0 and the stop bit at the top.
  assign startBit  = frame_q[0];
  assign dataByte  = frame_q[8:1];
  assign parityBit = frame_q[9];
  assign stopBit   = frame_q[FRAME_BITS-1];
  assign fifoPop   = rd & ~empty;
  assign busy      = (state_q != IDLE);

  // Receiver next state and per-frame result pulses
  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    wdog_d       = wdog_q;
    frame_d      = frame_q;
    fifoPush     = 1'b0;
    rx_done_tick = 1'b0;
    parity_err   = 1'b0;
    frame_err    = 1'b0;
    timeout_err  = 1'b0;
    overflow     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fallEdge && rx_en && (dSync_q == START_LEVEL)) begin
          frame_d  = {dSync_q, (FRAME_BITS-1)'(0)};
          bitCnt_d = BW'(FRAME_BITS - 1);
          wdog_d   = '0;
          state_d  = DPS;
        end
      end

      DPS: begin
        if (fallEdge) begin
          frame_d  = {dSync_q, frame_q[FRAME_BITS-1:1]};
          bitCnt_d = bitCnt_q - BW'(1);
          wdog_d   = '0;
          if (bitCnt_q == BW'(1)) begin
            state_d = CHECK;
          end
        end else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end

      CHECK: begin
        state_d = IDLE;
        if ((startBit != START_LEVEL) || (stopBit != STOP_LEVEL)) begin
          frame_err = 1'b1;
        end else if ((^{dataByte, parityBit}) == 1'b0) begin
          parity_err = 1'b1;
        end else if (!full || fifoPop) begin
          fifoPush     = 1'b1;
          rx_done_tick = 1'b1;
        end else begin
          overflow = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Receiver state, bit counter, watchdog and frame shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      wdog_q   <= '0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      wdog_q   <= wdog_d;
      frame_q  <= frame_d;
    end
  end

  ps2_rx_fifo_buf #(
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifoPush),
    .din_i   (dataByte),
    .pop_i   (rd),
    .dout_o  (dout),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
// Directed bench for ps2_rx_fifo. A frame-level model (sample runs, bit list,
// byte queue) predicts every output each cycle; literal expectations pin
// the headline results of each scenario.
module tb_ps2_rx_fifo;

  localparam int FL    = 4;
  localparam int DEPTH = 8;
  localparam int TO    = 300;
  localparam int HALF  = 10;
  localparam int GAP   = 30;

  logic       clk;
  logic       reset_n;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic       rd;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       busy;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  ps2_rx_fifo #(
    .FILTER_LEN  (FL),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .rx_en        (rx_en),
    .rd           (rd),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .busy         (busy),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .timeout_err  (timeout_err),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         mRunVal;
  int         mRunLen;
  bit         mFilt;
  bit         mD1, mD2;
  int         mMode;
  bit         mBits[$];
  logic [7:0] mQ[$];
  int         cycleNo;
  int         mLastEdge;
  bit         edgeNow, dNow, popNow, pushNow;
  bit         eDone, ePar, eFrm, eTo, eOvf;
  logic [7:0] mData;
  int         ones;
  int         doneCnt = 0, parCnt = 0, frmCnt = 0, toCnt = 0, ovfCnt = 0;

  always @(negedge clk) begin : modelCompare
    eDone = 0; ePar = 0; eFrm = 0; eTo = 0; eOvf = 0;
    pushNow = 0; popNow = 0; edgeNow = 0; dNow = 1;
    mData = 8'h00;
    if (!reset_n) begin
      mRunVal = 1; mRunLen = FL; mFilt = 1; mD1 = 1; mD2 = 1;
      mMode = 0; mBits.delete(); mQ.delete();
    end else begin
      edgeNow = mFilt && !mRunVal && (mRunLen >= FL);
      dNow    = mD2;
      popNow  = rd && (mQ.size() > 0);
      if (mMode == 2) begin
        for (int i = 0; i < 8; i++) mData[i] = mBits[i+1];
        ones = $countones(mData) + int'(mBits[9]);
        if (mBits[0] != 0 || mBits[10] != 1) eFrm = 1;
        else if (ones % 2 == 0) ePar = 1;
        else if (mQ.size() < DEPTH || popNow) begin eDone = 1; pushNow = 1; end
        else eOvf = 1;
      end
      if (mMode == 1 && !edgeNow && (cycleNo - mLastEdge) == TO) eTo = 1;
    end

    checkOutput("dout", dout, (mQ.size() > 0) ? mQ[0] : 8'h00);
    checkOutput("empty", empty, mQ.size() == 0);
    checkOutput("full", full, mQ.size() == DEPTH);
    checkOutput("count", count, mQ.size());
    checkOutput("busy", busy, mMode != 0);
    checkOutput("rx_done_tick", rx_done_tick, eDone);
    checkOutput("parity_err", parity_err, ePar);
    checkOutput("frame_err", frame_err, eFrm);
    checkOutput("timeout_err", timeout_err, eTo);
    checkOutput("overflow", overflow, eOvf);

    doneCnt += int'(rx_done_tick === 1'b1);
    parCnt  += int'(parity_err === 1'b1);
    frmCnt  += int'(frame_err === 1'b1);
    toCnt   += int'(timeout_err === 1'b1);
    ovfCnt  += int'(overflow === 1'b1);

    if (reset_n) begin
      if (popNow) void'(mQ.pop_front());
      if (pushNow) mQ.push_back(mData);
      case (mMode)
        2: begin mMode = 0; mBits.delete(); end
        1: begin
          if (edgeNow) begin
            mBits.push_back(dNow);
            mLastEdge = cycleNo;
            if (mBits.size() == 11) mMode = 2;
          end else if (eTo) begin
            mMode = 0; mBits.delete();
          end
        end
        default: begin
          if (edgeNow && rx_en && dNow == 0) begin
            mBits.delete(); mBits.push_back(1'b0);
            mLastEdge = cycleNo; mMode = 1;
          end
        end
      endcase
      if (mRunLen >= FL) mFilt = mRunVal;
      if (ps2c == mRunVal) begin
        if (mRunLen < FL) mRunLen++;
      end else begin
        mRunVal = ps2c; mRunLen = 1;
      end
      mD2 = mD1;
      mD1 = ps2d;
    end
    cycleNo++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic oddPar(input logic [7:0] d);
    return ~(^d);
  endfunction

  // Sends the first nBits of a frame; optional glitch in bit 4's high phase
  // and optional rd pulse during the frame's check cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic parBit, input logic stopBit,
                               input int nBits, input bit glitch, input bit rdAtCheck);
    logic [10:0] bits;
    bit rdDone;
    bits = {stopBit, parBit, data, 1'b0};
    rdDone = 0;
    for (int i = 0; i < nBits; i++) begin
      ps2d = bits[i];
      if (glitch && i == 4) begin
        tick(3); ps2c = 1'b0; tick(FL - 1); ps2c = 1'b1; tick(HALF - 3 - (FL - 1));
      end else begin
        tick(HALF);
      end
      ps2c = 1'b0;
      for (int j = 0; j < HALF; j++) begin
        tick(1);
        if (rdAtCheck && !rdDone && mMode == 2) begin
          rd = 1'b1; tick(1); rd = 1'b0; rdDone = 1;
        end
      end
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    tick(GAP);
    if (rdAtCheck) checkOutput("rdAtCheckReached", rdDone, 1);
  endtask

  task automatic popByte(input logic [7:0] exp);
    @(negedge clk);
    checkOutput("popDout", dout, exp);
    checkOutput("popNotEmpty", empty, 0);
    @(posedge clk); #1;
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  initial begin : globalTimeout
    #1000000;
    $display("[TB] FAIL globalTimeout: simulation did not finish in time");
    $fatal(1, "[TB] time limit reached");
  end

  // ---------------- directed sequence ----------------
  initial begin : mainSeq
    int d0, p0, f0, t0, o0;
    ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rd = 1'b0; reset_n = 1'b0;
    cycleNo = 0; mLastEdge = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstEmpty", empty, 1);
    checkOutput("rstFull", full, 0);
    checkOutput("rstCount", count, 0);
    checkOutput("rstDout", dout, 8'h00);
    checkOutput("rstBusy", busy, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(10);

    // valid 0x1C
    d0 = doneCnt;
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, 0, 0);
    checkOutput("done1C", doneCnt - d0, 1);
    checkOutput("model1C", mQ.size(), 1);
    @(negedge clk);
    checkOutput("dout1C", dout, 8'h1C);
    checkOutput("count1C", count, 1);
    popByte(8'h1C);
    tick(2);
    @(negedge clk);
    checkOutput("emptyAfterRd", empty, 1);
    checkOutput("countAfterRd", count, 0);

    // parity error, then framing error
    tick(1);
    d0 = doneCnt; p0 = parCnt; f0 = frmCnt;
    applyStimulus(8'h1C, 1'b1, 1'b1, 11, 0, 0);
    checkOutput("parErrOnce", parCnt - p0, 1);
    checkOutput("parNoDone", doneCnt - d0, 0);
    checkOutput("parEmpty", empty, 1);
    p0 = parCnt;
    applyStimulus(8'h1C, 1'b0, 1'b0, 11, 0, 0);
    checkOutput("frmErrOnce", frmCnt - f0, 1);
    checkOutput("frmNoPar", parCnt - p0, 0);
    checkOutput("frmNoDone", doneCnt - d0, 0);

    // overflow on the ninth frame
    d0 = doneCnt; o0 = ovfCnt;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      logic [7:0] b;
      b = 8'(i);
      applyStimulus(b, oddPar(b), 1'b1, 11, 0, 0);
    end
    checkOutput("ovfDone", doneCnt - d0, 8);
    checkOutput("ovfOnce", ovfCnt - o0, 1);
    checkOutput("ovfFull", full, 1);
    for (int i = 1; i <= DEPTH; i++) popByte(8'(i));
    tick(2);

    // refill, then push while full with rd in the check cycle
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] b;
      b = 8'h11 + 8'(i);
      applyStimulus(b, oddPar(b), 1'b1, 11, 0, 0);
    end
    checkOutput("refillCount", count, 8);
    d0 = doneCnt; o0 = ovfCnt;
    applyStimulus(8'h55, oddPar(8'h55), 1'b1, 11, 0, 1);
    checkOutput("fullRdDone", doneCnt - d0, 1);
    checkOutput("fullRdNoOvf", ovfCnt - o0, 0);
    checkOutput("fullRdCount", count, 8);
    for (int i = 0; i < DEPTH - 1; i++) popByte(8'h12 + 8'(i));
    popByte(8'h55);
    tick(2);
    checkOutput("drainedEmpty", empty, 1);

    // watchdog timeout after 5 bits, then a clean 0xF0
    t0 = toCnt; f0 = frmCnt; p0 = parCnt; d0 = doneCnt;
    applyStimulus(8'hF0, oddPar(8'hF0), 1'b1, 5, 0, 0);
    tick(TO + 20);
    checkOutput("timeoutOnce", toCnt - t0, 1);
    checkOutput("timeoutBusy", busy, 0);
    checkOutput("timeoutNoOther", (frmCnt - f0) + (parCnt - p0) + (doneCnt - d0), 0);
    applyStimulus(8'hF0, oddPar(8'hF0), 1'b1, 11, 0, 0);
    popByte(8'hF0);
    tick(2);

    // idle glitch with data low: no start
    d0 = doneCnt; p0 = parCnt; f0 = frmCnt; t0 = toCnt;
    ps2d = 1'b0; tick(HALF);
    ps2c = 1'b0; tick(FL - 1); ps2c = 1'b1;
    tick(2);
    checkOutput("glitchIdleBusy", busy, 0);
    tick(HALF);
    ps2d = 1'b1; tick(HALF);
    // mid-frame glitch leaves the byte intact
    applyStimulus(8'hA5, oddPar(8'hA5), 1'b1, 11, 1, 0);
    checkOutput("glitchFrameDone", doneCnt - d0, 1);
    checkOutput("glitchNoErr", (parCnt - p0) + (frmCnt - f0) + (toCnt - t0), 0);
    popByte(8'hA5);
    tick(2);

    // rx_en low at the start bit
    d0 = doneCnt;
    rx_en = 1'b0;
    applyStimulus(8'h33, oddPar(8'h33), 1'b1, 11, 0, 0);
    rx_en = 1'b1;
    checkOutput("rxEnOffNoDone", doneCnt - d0, 0);
    checkOutput("rxEnOffEmpty", empty, 1);

    // reset mid-frame with two bytes buffered
    applyStimulus(8'hA1, oddPar(8'hA1), 1'b1, 11, 0, 0);
    applyStimulus(8'hB2, oddPar(8'hB2), 1'b1, 11, 0, 0);
    checkOutput("preRstCount", count, 2);
    applyStimulus(8'h3C, oddPar(8'h3C), 1'b1, 6, 0, 0);
    checkOutput("preRstBusy", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midRstEmpty", empty, 1);
    checkOutput("midRstCount", count, 0);
    checkOutput("midRstBusy", busy, 0);
    tick(3);
    reset_n = 1'b1;
    tick(10);
    d0 = doneCnt;
    applyStimulus(8'h5A, oddPar(8'h5A), 1'b1, 11, 0, 0);
    checkOutput("postRstDone", doneCnt - d0, 1);
    checkOutput("postRstCount", count, 1);
    popByte(8'h5A);
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with a configurable clock glitch filter, full frame validation (start, odd parity, stop), an inter-bit watchdog and a receive FIFO. It sits between the PS/2 pins and the keyboard/scan-code decoding logic. It replaces the single-byte, unchecked receiver with a buffered interface that flags every error.

## Interface
- FILTER_LEN, 8: number of consecutive identical ps2c samples required to change the filtered clock (≥2).
- FIFO_DEPTH, 8: receive FIFO entries (power of two, ≥2).
- TIMEOUT_CYC, 50000: clk cycles allowed between filtered falling edges inside a frame (≥2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ps2c  in  1  raw PS/2 clock pin
- ps2d  in  1  raw PS/2 data pin
- rx_en  in  1  permits a new frame to start
- rd  in  1  pop FIFO head
- dout  out  8  FIFO head (first-word fall-through), valid when empty=0
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- busy  out  1  state ≠ IDLE
- rx_done_tick  out  1  one-cycle pulse: valid byte pushed
- parity_err, frame_err, timeout_err, overflow  out  1 each  one-cycle error pulses

## Operation
- Reset values: filter register all ones, filtered clock 1, ps2d synchroniser 1, state IDLE, FIFO empty (empty=1, full=0, count=0, dout=0), all pulses 0, busy 0.
- ps2d passes through a 2-FF synchroniser. ps2c is shifted into a FILTER_LEN-bit register. The filtered clock becomes 1 when the register is all ones, becomes 0 when it is all zeros, and holds otherwise.
- fall_edge = filtered_reg & ~filtered_next. ps2d is sampled only on fall_edge. Frame is LSB-first: start(0), d0..d7, parity, stop(1), giving 11 bits.
- State IDLE:
  - fall_edge & rx_en & sampled ps2d==0 → store start bit, load bit counter to 10, clear watchdog, go to DPS.
  - Start bit sampled as 1 → ignored, stay in IDLE.
  - fall_edge with rx_en=0 → ignored.
- State DPS:
  - Each fall_edge shifts in a bit, decrements the counter and clears the watchdog.
  - The fall_edge that shifts in the 11th bit (counter 1→0) → go to CHECK.
  - The watchdog increments on every non-edge cycle. On reaching TIMEOUT_CYC-1 → timeout_err pulse, partial frame discarded, go to IDLE.
  - rx_en deasserting mid-frame does not abort the frame.
- State CHECK (one cycle), then always IDLE:
  - start≠0 or stop≠1 → frame_err.
  - Otherwise, XOR of data and parity bit ≠1 → parity_err.
  - Otherwise, if FIFO not full, or full with rd this cycle → push, rx_done_tick.
  - Otherwise → overflow, byte dropped.
  - Only one pulse is raised per frame; frame_err has priority over parity_err.
- FIFO:
  - rd while empty is ignored.
  - Push and pop in the same cycle keep count unchanged and do not raise overflow, including when full.
  - Read and write pointers are clog2(FIFO_DEPTH) bits wide and wrap naturally.

## Timing
- The filtered clock lags raw ps2c by FILTER_LEN+1 clk cycles. Glitches shorter than FILTER_LEN cycles produce no edge.
- Last data edge detected in cycle T → CHECK in T+1 → rx_done_tick/error pulse in T+1 → dout valid and empty=0 from T+2.
- rd at cycle R: dout shows the next entry (or empty=1) from R+1.
- reset_n asserted mid-frame immediately forces IDLE, flushes the FIFO and clears all pulses. No frame is reported after release until a new start bit arrives.

## Structure
- Shared package/include ps2_defs: state encodings (IDLE, DPS, CHECK), FRAME_BITS=11, start/stop level constants, and a clog2 function.
- One sub-module, ps2_rx_fifo_buf: a synchronous first-word-fall-through FIFO (parameter DEPTH, width 8) exposing push, pop, dout, empty, full, count.
- The filter, synchroniser, FSM and watchdog stay in the top module.

## Test plan
- Frame 0x1C with parity bit 0 and stop 1 → rx_done_tick once, empty falls, dout=0x1C, count=1. After rd, empty=1 and count=0.
- Frame 0x1C with parity bit 1 → parity_err once, no rx_done_tick, FIFO stays empty. Same frame with stop bit 0 → frame_err only.
- Send FIFO_DEPTH+1 valid frames 0x01.. without reads → full=1, overflow on the last frame, reads return 0x01..0x08 in order. Then with the FIFO full, assert rd in the CHECK cycle of a new frame → rx_done_tick, no overflow, count stays FIFO_DEPTH.
- Stop ps2c high after 5 bits for TIMEOUT_CYC cycles → timeout_err once, busy=0. A following clean frame 0xF0 is received with dout=0xF0.
- ps2c glitches of FILTER_LEN-1 cycles low while idle or mid-frame → no edges, no pulses, frame content unaffected. rx_en=0 at a start bit → frame ignored.
- Assert reset_n low after 6 bits with 2 bytes buffered → immediately empty=1, count=0, busy=0. After release, the next valid frame is received correctly.
